// File: rtl/display_bcd_converter_pkg.sv
// Shared constants and FSM encoding for the display BCD converter.
package display_pkg;

    localparam int          DIGITS      = 8;
    localparam logic [31:0] BCD_MAX     = 32'd99_999_999;
    localparam logic [31:0] OVF_PATTERN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/display_bcd_converter.sv
// Sequential binary-to-BCD converter feeding the 8-digit seven-segment driver.
// Define DISPLAY_LZ_BLANK_EN to blank leading zero digits in enable_out.
module display_bcd_converter
    import display_pkg::*;
#(
    parameter int BIN_W = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin_in,
    input  logic [7:0]       point_in,
    output logic [31:0]      value_out,
    output logic [7:0]       enable_out,
    output logic [7:0]       point_out,
    output logic             overflow,
    output logic             done
);

    // Handshake: a request is taken on the rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, so requests during a conversion are ignored.

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [31:0]        r_bcd;
    logic [7:0]         r_point;
    logic [5:0]         r_cnt;
    logic               r_ovf;

    logic [31:0]        w_adj;
    logic [BIN_W+31:0]  w_next;
    logic [7:0]         w_enable;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // The bit shifted out of the accumulator MSB falls off the top here.
    assign w_next   = {w_adj, r_bin} << 1;
    assign in_ready = (r_state == IDLE);

`ifdef DISPLAY_LZ_BLANK_EN
    logic w_seen;
    always_comb begin
        w_seen   = 1'b0;
        w_enable = 8'h00;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
            w_enable[i] = w_seen;
        end
        w_enable[0] = 1'b1;
    end
`else
    assign w_enable = 8'hFF;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_point    <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            value_out  <= '0;
            enable_out <= 8'h00;
            point_out  <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= bin_in;
                        r_point <= point_in;
                        r_bcd   <= '0;
                        r_cnt   <= 6'(BIN_W);
                        r_ovf   <= (32'(bin_in) > BCD_MAX);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_next[BIN_W +: 32];
                    r_bin <= w_next[BIN_W-1:0];
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (r_ovf) begin
                        value_out  <= OVF_PATTERN;
                        enable_out <= 8'hFF;
                        point_out  <= 8'h00;
                        overflow   <= 1'b1;
                    end else begin
                        value_out  <= r_bcd;
                        enable_out <= w_enable;
                        point_out  <= r_point;
                        overflow   <= 1'b0;
                    end
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_converter.sv
// Self-checking bench for display_bcd_converter: directed cases plus random values
// checked against a decimal-arithmetic reference model.
module tb_display_bcd_converter;

    localparam int BIN_W = 27;
    localparam int LAT   = BIN_W + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] bin_in;
    logic [7:0]       point_in;
    logic [31:0]      value_out;
    logic [7:0]       enable_out;
    logic [7:0]       point_out;
    logic             overflow;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    display_bcd_converter #(.BIN_W(BIN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin_in     (bin_in),
        .point_in   (point_in),
        .value_out  (value_out),
        .enable_out (enable_out),
        .point_out  (point_out),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: decimal digits by division, no knowledge of shift-and-add.
    function automatic logic [31:0] ref_value(input longint v);
        logic [31:0] r;
        longint      t;
        r = '0;
        if (v > 99_999_999) return 32'hFFFF_FFFF;
        t = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_enable(input longint v);
        int     n;
        longint t;
        if (v > 99_999_999) return 8'hFF;
`ifdef DISPLAY_LZ_BLANK_EN
        n = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            n++;
        end
        return 8'((1 << n) - 1);
`else
        n = 0;
        t = 0;
        return 8'hFF;
`endif
    endfunction

    function automatic logic [7:0] ref_point(input longint v, input logic [7:0] p);
        return (v > 99_999_999) ? 8'h00 : p;
    endfunction

    // Returns right after the accepting rising edge, with in_valid dropped.
    task automatic send(input logic [BIN_W-1:0] b, input logic [7:0] p);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("ready_wait", 32'(waited < 100), 32'd1);
        bin_in   = b;
        point_in = p;
        in_valid = 1'b1;
        exp_q.push_back(ref_value(longint'(b)));
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done_check(input logic [BIN_W-1:0] b, input logic [7:0] p, input string tag);
        int          lat;
        logic [31:0] exp_v;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!done && lat < 200);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_value"},    value_out,         exp_v);
        check({tag, "_enable"},   32'(enable_out),   32'(ref_enable(longint'(b))));
        check({tag, "_point"},    32'(point_out),    32'(ref_point(longint'(b), p)));
        check({tag, "_overflow"}, 32'(overflow),     32'(longint'(b) > 99_999_999));
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run_one(input logic [BIN_W-1:0] b, input logic [7:0] p, input string tag);
        send(b, p);
        wait_done_check(b, p, tag);
    endtask

    initial begin
        int          low;
        int          pulses;
        logic [BIN_W-1:0] a_v;
        logic [BIN_W-1:0] b_v;
        logic [BIN_W-1:0] rv;
        logic [7:0]  rp;
        logic [31:0] held;

        reset    = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        point_in = '0;

        repeat (3) @(negedge clock);
        check("rst_value",  value_out,        32'h0);
        check("rst_enable", 32'(enable_out),  32'h00);
        check("rst_ready",  32'(in_ready),    32'd1);
        check("rst_done",   32'(done),        32'd0);
        reset = 1'b1;

        run_one(BIN_W'(12_345_678), 8'h04, "basic");
        run_one(BIN_W'(0),          8'h00, "zero");
        run_one(BIN_W'(305),        8'h02, "v305");
        run_one(BIN_W'(100_000_000), 8'h81, "ovf");
        run_one(BIN_W'(99_999_999), 8'h10, "max_bcd");
        run_one(BIN_W'((1 << BIN_W) - 1), 8'hFF, "max_bin");

        held = value_out;
        repeat (15) @(negedge clock);
        check("idle_hold", value_out, held);

        // Back-to-back: in_valid stays high across two requests.
        a_v = BIN_W'(87_654_321);
        b_v = BIN_W'(1_000);
        @(negedge clock);
        bin_in   = a_v;
        point_in = 8'h01;
        in_valid = 1'b1;
        exp_q.push_back(ref_value(longint'(a_v)));
        @(posedge clock);
        #1 bin_in = b_v;
        point_in = 8'h20;
        low = 0;
        @(negedge clock);
        while (!in_ready && low < 100) begin
            low++;
            @(negedge clock);
        end
        check("b2b_ready_low_a", 32'(low), 32'(LAT));
        check("b2b_done_a", 32'(done), 32'd1);
        check("b2b_value_a", value_out, exp_q.pop_front());
        exp_q.push_back(ref_value(longint'(b_v)));
        @(posedge clock);
        #1 in_valid = 1'b0;
        low = 0;
        @(negedge clock);
        while (!in_ready && low < 100) begin
            low++;
            @(negedge clock);
        end
        check("b2b_ready_low_b", 32'(low), 32'(LAT));
        check("b2b_done_b", 32'(done), 32'd1);
        check("b2b_value_b", value_out, exp_q.pop_front());
        check("b2b_point_b", 32'(point_out), 32'h20);

        // Reset ten cycles into SHIFT.
        send(BIN_W'(55_555_555), 8'h0F);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_value",    value_out,       32'h0);
        check("mid_rst_enable",   32'(enable_out), 32'h00);
        check("mid_rst_point",    32'(point_out),  32'h00);
        check("mid_rst_overflow", 32'(overflow),   32'd0);
        check("mid_rst_ready",    32'(in_ready),   32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        run_one(BIN_W'(42), 8'h00, "after_rst");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = BIN_W'($urandom_range(0, 999));
                1:       rv = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
                2:       rv = BIN_W'($urandom_range(0, 99_999_999));
                default: rv = BIN_W'($urandom_range(99_999_990, 100_000_010));
            endcase
            rp = 8'($urandom_range(0, 255));
            run_one(rv, rp, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
